spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_master_if.sv | 27 ++
 rtl/spi_clk_div.sv | 41 ++++
 rtl/spi_master.sv | 163 ++++++++++++++++
 tb/tb_spi_master.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and FSM state encoding
package spi_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 4;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_TRAIL,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - byte stream and SPI pin bundle for spi_master
interface spi_master_if #(
  parameter int DATA_WIDTH = spi_pkg::DEF_DATA_WIDTH
);

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  cs;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  tx_valid, tx_data, miso,
    output tx_ready, rx_valid, rx_data, busy, cs, sclk, mosi
  );

  modport slave (
    output tx_valid, tx_data, miso,
    input  tx_ready, rx_valid, rx_data, busy, cs, sclk, mosi
  );

endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - free-running 0..CLK_DIV-1 counter with terminal-count tick
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_clk_div: CLK_DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  // Next count: restart on clear or after the terminal count.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, MSB first; SPI_MASTER_BURST_EN keeps cs low across queued bytes
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("spi_master: DATA_WIDTH must be at least 2");
  end

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tick;
  logic                  div_clear;
  logic                  tx_ready;
  logic                  load;

  // Divider restarts whenever the FSM moves, so every state lasts whole half-periods.
  assign div_clear = (state_q == ST_IDLE) || (state_d != state_q);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clear(div_clear),
    .tick (tick)
  );

  assign bus.tx_ready = tx_ready;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.cs       = cs_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;

  // Next state and next values of every output register.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready   = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        load     = bus.tx_valid;
      end

      // Rising sclk edge: shift miso in at the LSB, the next mosi bit surfaces at the MSB.
      ST_SETUP, ST_LOW: begin
        if (tick) begin
          state_d   = ST_HIGH;
          sclk_d    = ~CPOL;
          shift_d   = {shift_q[DATA_WIDTH-2:0], bus.miso};
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

      ST_HIGH: begin
        if (tick) begin
          sclk_d = CPOL;
          if (bit_cnt_q < LAST_BIT) begin
            state_d = ST_LOW;
            mosi_d  = shift_q[DATA_WIDTH-1];
          end else begin
            state_d = ST_TRAIL;
          end
        end
      end

      ST_TRAIL: begin
        if (tick) begin
          rx_valid_d = 1'b1;
          rx_data_d  = shift_q;
`ifdef SPI_MASTER_BURST_EN
          tx_ready = 1'b1;
          load     = bus.tx_valid;
          if (!bus.tx_valid) begin
            cs_d    = 1'b1;
            state_d = ST_GAP;
          end
`else
          cs_d    = 1'b1;
          state_d = ST_GAP;
`endif
        end
      end

      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame start, shared by IDLE acceptance and burst continuation.
    if (load) begin
      state_d   = ST_SETUP;
      shift_d   = bus.tx_data;
      bit_cnt_d = '0;
      cs_d      = 1'b0;
      mosi_d    = bus.tx_data[DATA_WIDTH-1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and pin registers; reset drops cs and parks sclk/mosi immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed scoreboard bench for spi_master (CLK_DIV 4 and 2)
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  spi_master_if #(.DATA_WIDTH(8)) a_if ();
  spi_master_if #(.DATA_WIDTH(8)) b_if ();

  bit         loopback   = 1'b0;
  logic       slave_bit  = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [2:0] slave_idx  = 3'd0;
  logic       slave_prev_sclk = 1'b0;

  assign a_if.miso = loopback ? a_if.mosi : slave_bit;
  assign b_if.miso = b_if.mosi;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mode-0 slave: presents its MSB when cs falls, next bit after each sclk fall.
  always @(negedge clk) begin
    if (a_if.cs) slave_idx = 3'd0;
    else if (slave_prev_sclk && !a_if.sclk) slave_idx = slave_idx + 3'd1;
    slave_prev_sclk = a_if.sclk;
    slave_bit = slave_byte[3'd7 - slave_idx];
  end

  logic [7:0] exp_q[$];
  int acc_cyc = 0, prev_acc_cyc = 0, rx_cyc = 0, prev_rx_cyc = 0, rx_count = 0;
  int rises = 0, rises_total = 0, cs_run = 0, last_cs_run = 0, cs_rises = 0;
  int ready_cyc = 0, ready_busy_viol = 0;
  logic [7:0] mosi_rec = 8'h00;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_ready = 1'b1;

  // Monitor for the CLK_DIV=4 instance; pops the scoreboard on each rx_valid.
  always @(negedge clk) begin
    if (a_if.tx_valid && a_if.tx_ready) begin
      prev_acc_cyc = acc_cyc; acc_cyc = cyc; rises = 0;
    end
    if (a_if.sclk && !prev_sclk) begin
      rises++; rises_total++; mosi_rec = {mosi_rec[6:0], a_if.mosi};
    end
    if (!a_if.cs) cs_run++;
    else if (!prev_cs) begin last_cs_run = cs_run; cs_run = 0; cs_rises++; end
    if (a_if.tx_ready && !prev_ready) ready_cyc = cyc;
    if (a_if.tx_ready && a_if.busy) ready_busy_viol++;
    if (a_if.rx_valid) begin
      prev_rx_cyc = rx_cyc; rx_cyc = cyc; rx_count++;
      if (exp_q.size() == 0) chk("rx_unexpected", 32'(exp_q.size()), 32'd1);
      else chk("rx_data", 32'(a_if.rx_data), 32'(exp_q.pop_front()));
    end
    prev_sclk = a_if.sclk; prev_cs = a_if.cs; prev_ready = a_if.tx_ready;
  end

  logic [7:0] exp_b[$];
  int b_rise_cyc = 0, b_prev_rise_cyc = 0, b_rises = 0, b_cs_run = 0, b_last_cs_run = 0, b_rx_count = 0;
  logic b_prev_sclk = 1'b0, b_prev_cs = 1'b1;

  // Monitor for the CLK_DIV=2 instance.
  always @(negedge clk) begin
    if (b_if.sclk && !b_prev_sclk) begin b_prev_rise_cyc = b_rise_cyc; b_rise_cyc = cyc; b_rises++; end
    if (!b_if.cs) b_cs_run++;
    else if (!b_prev_cs) begin b_last_cs_run = b_cs_run; b_cs_run = 0; end
    if (b_if.rx_valid) begin
      b_rx_count++;
      if (exp_b.size() == 0) chk("b_rx_unexpected", 32'(exp_b.size()), 32'd1);
      else chk("b_rx_data", 32'(b_if.rx_data), 32'(exp_b.pop_front()));
    end
    b_prev_sclk = b_if.sclk; b_prev_cs = b_if.cs;
  end

  task automatic send_a(input logic [7:0] d, input bit hold);
    int k = 0;
    @(posedge clk); #1;
    a_if.tx_data  = d;
    a_if.tx_valid = 1'b1;
    exp_q.push_back(loopback ? d : slave_byte);
    @(negedge clk);
    while (!a_if.tx_ready && k < 1000) begin @(negedge clk); k++; end
    chk("send_a_ready", 32'(a_if.tx_ready), 32'd1);
    @(posedge clk); #1;
    if (!hold) a_if.tx_valid = 1'b0;
  endtask

  task automatic wait_rx_a(input int n);
    int k = 0;
    while (rx_count < n && k < 1000) begin @(negedge clk); #1; k++; end
    chk("wait_rx_a", 32'(rx_count), 32'(n));
  endtask

  int n0, cr0, rt0, k;

  initial begin
    a_if.tx_valid = 1'b0; a_if.tx_data = 8'h00;
    b_if.tx_valid = 1'b0; b_if.tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 32'(a_if.cs), 32'd1);
    chk("rst_sclk", 32'(a_if.sclk), 32'd0);
    chk("rst_mosi", 32'(a_if.mosi), 32'd0);
    chk("rst_tx_ready", 32'(a_if.tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(a_if.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(a_if.rx_data), 32'd0);
    chk("rst_busy", 32'(a_if.busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single byte A5 out, 3C in.
    loopback = 1'b0; slave_byte = 8'h3C; n0 = rx_count;
    send_a(8'hA5, 1'b0);
    wait_rx_a(n0 + 1);
    chk("single_rx_latency", 32'(rx_cyc - acc_cyc), 32'd69);
    chk("single_mosi_bits", 32'(mosi_rec), 32'hA5);
    chk("single_sclk_rises", 32'(rises), 32'd8);
    chk("single_cs_low", 32'(last_cs_run), 32'd68);
    @(negedge clk); #1;
    chk("single_rx_pulse_len", 32'(a_if.rx_valid), 32'd0);
    chk("single_rx_hold", 32'(a_if.rx_data), 32'h3C);
    k = 0;
    while (!a_if.tx_ready && k < 200) begin @(negedge clk); #1; k++; end
`ifndef SPI_MASTER_BURST_EN
    chk("single_ready_again", 32'(ready_cyc - acc_cyc), 32'd73);
`endif

`ifndef SPI_MASTER_BURST_EN
    // Back-to-back with tx_valid held.
    loopback = 1'b1; n0 = rx_count; cr0 = cs_rises;
    send_a(8'h01, 1'b1);
    send_a(8'hFF, 1'b0);
    wait_rx_a(n0 + 2);
    chk("b2b_accept_gap", 32'(acc_cyc - prev_acc_cyc), 32'd73);
    chk("b2b_rx_gap", 32'(rx_cyc - prev_rx_cyc), 32'd73);
    chk("b2b_cs_rises", 32'(cs_rises - cr0), 32'd2);
`endif

    // Loopback, 16 random bytes.
    loopback = 1'b1; n0 = rx_count; ready_busy_viol = 0;
    for (int i = 0; i < 16; i++) send_a(8'($urandom_range(0, 255)), 1'b0);
    wait_rx_a(n0 + 16);
`ifndef SPI_MASTER_BURST_EN
    chk("loop_ready_while_busy", 32'(ready_busy_viol), 32'd0);
`endif
    repeat (10) @(posedge clk);

    // Reset at cycle 30 of a frame.
    loopback = 1'b0; slave_byte = 8'h5A; n0 = rx_count;
    @(posedge clk); #1;
    a_if.tx_data = 8'hC3; a_if.tx_valid = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(a_if.tx_ready), 32'd1);
    @(posedge clk); #1;
    a_if.tx_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("abort_pre_sclk", 32'(a_if.sclk), 32'd1);
    chk("abort_pre_cs", 32'(a_if.cs), 32'd0);
    rst = 1'b1; #1;
    chk("abort_cs", 32'(a_if.cs), 32'd1);
    chk("abort_sclk", 32'(a_if.sclk), 32'd0);
    chk("abort_mosi", 32'(a_if.mosi), 32'd0);
    chk("abort_busy", 32'(a_if.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    chk("abort_no_rx", 32'(rx_count), 32'(n0));
    slave_byte = 8'h96;
    send_a(8'h3E, 1'b0);
    wait_rx_a(n0 + 1);
    chk("abort_next_mosi", 32'(mosi_rec), 32'h3E);
    repeat (10) @(posedge clk);

    // CLK_DIV=2 instance, loopback.
    @(posedge clk); #1;
    b_if.tx_data = 8'h6B; b_if.tx_valid = 1'b1; exp_b.push_back(8'h6B);
    @(negedge clk);
    chk("b_ready", 32'(b_if.tx_ready), 32'd1);
    @(posedge clk); #1;
    b_if.tx_valid = 1'b0;
    k = 0;
    while (b_rx_count < 1 && k < 200) begin @(negedge clk); #1; k++; end
    chk("b_rx_count", 32'(b_rx_count), 32'd1);
    chk("b_cs_low", 32'(b_last_cs_run), 32'd34);
    chk("b_sclk_period", 32'(b_rise_cyc - b_prev_rise_cyc), 32'd4);
    chk("b_sclk_rises", 32'(b_rises), 32'd8);

`ifdef SPI_MASTER_BURST_EN
    // Burst of three queued bytes under one cs.
    repeat (10) @(posedge clk);
    loopback = 1'b1; n0 = rx_count; cr0 = cs_rises; rt0 = rises_total;
    send_a(8'h81, 1'b1);
    send_a(8'h42, 1'b1);
    send_a(8'hE7, 1'b0);
    wait_rx_a(n0 + 3);
    repeat (10) @(posedge clk);
    chk("burst_cs_rises", 32'(cs_rises - cr0), 32'd1);
    chk("burst_sclk_rises", 32'(rises_total - rt0), 32'd24);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
